// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_FWD = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam logic [3:0] OP_ROR = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per clock,
// done asserts combinationally during the final step with the full product.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] a_p0;
  logic [2*WIDTH-1:0] acc_p0;
  logic [WIDTH-1:0]   b_p0;
  logic [CW-1:0]      cnt_p0;
  logic               busy;

  // product is the accumulator after the current step, so the last step's
  // value is available in the same cycle done is raised
  assign product = acc_p0 + (b_p0[0] ? a_p0 : '0);
  assign done    = busy && (cnt_p0 == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt_p0 <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt_p0 <= '0;
    end else if (done) begin
      busy   <= 1'b0;
    end else if (busy) begin
      cnt_p0 <= cnt_p0 + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      a_p0   <= {{WIDTH{1'b0}}, a};
      b_p0   <= b;
      acc_p0 <= '0;
    end else if (busy) begin
      acc_p0 <= product;
      a_p0   <= a_p0 << 1;
      b_p0   <= b_p0 >> 1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered execute-stage ALU: single-cycle logic/arith ops, bit-serial
// shifts and an iterative multiplier behind a valid/ready handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [3:0]       SELECT,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             CARRY,
  output logic             OVF
);

  // Returns {carry, result} for every op that completes in the accept cycle.
  function automatic logic [WIDTH:0] alu_single(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    r = '0;
    case (op)
      OP_FWD: r = {1'b0, b};
      OP_ADD: r = {1'b0, a} + {1'b0, b};
      OP_AND: r = {1'b0, a & b};
      OP_OR:  r = {1'b0, a | b};
      OP_SUB: begin
        r = {1'b0, a} - {1'b0, b};
        r[WIDTH] = ~r[WIDTH];
      end
      OP_SLL, OP_SRL, OP_SRA, OP_ROR: r = {1'b0, a};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] shift_step(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] sv;
    logic [WIDTH-1:0]        r;
    sv = signed'(v);
    case (op)
      OP_SLL:  r = v << 1;
      OP_SRL:  r = v >> 1;
      OP_SRA:  r = sv >>> 1;
      OP_ROR:  r = {v[0], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  state_t             state, next_state;
  logic               accept, is_mul, is_shift;
  logic               start_mul, start_shift, single;
  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     single_res;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [3:0]         op_p0;
  logic [WIDTH-1:0]   sh_val_p0, sh_next;
  logic [SHW-1:0]     sh_cnt_p0;
  logic               shift_done;

  assign IN_READY    = (state == ST_IDLE);
  assign accept      = IN_VALID && IN_READY;
  assign shamt       = DATA2[SHW-1:0];
  assign is_mul      = (SELECT == OP_MUL);
  assign is_shift    = (SELECT == OP_SLL) || (SELECT == OP_SRL) ||
                       (SELECT == OP_SRA) || (SELECT == OP_ROR);
  assign start_mul   = accept && is_mul;
  assign start_shift = accept && is_shift && (shamt != '0);
  assign single      = accept && !start_mul && !start_shift;
  assign single_res  = alu_single(SELECT, DATA1, DATA2);
  assign sh_next     = shift_step(op_p0, sh_val_p0);
  assign shift_done  = (state == ST_SHIFT) && (sh_cnt_p0 == SHW'(1));
  assign ZERO        = (RESULT == '0);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (CLK),
    .rst     (RESET),
    .start   (start_mul),
    .a       (DATA1),
    .b       (DATA2),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start_mul)        next_state = ST_MUL;
        else if (start_shift) next_state = ST_SHIFT;
      end
      ST_MUL:   if (mul_done)   next_state = ST_IDLE;
      ST_SHIFT: if (shift_done) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Shift stage: operand and remaining count captured at accept
  always_ff @(posedge CLK) begin
    if (start_shift) begin
      op_p0     <= SELECT;
      sh_val_p0 <= DATA1;
      sh_cnt_p0 <= shamt;
    end else if (state == ST_SHIFT) begin
      sh_val_p0 <= sh_next;
      sh_cnt_p0 <= sh_cnt_p0 - SHW'(1);
    end
  end

  // Completion stage: exactly one of the three sources can fire per cycle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      RESULT    <= '0;
      CARRY     <= 1'b0;
      OVF       <= 1'b0;
      OUT_VALID <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      if (single) begin
        RESULT    <= single_res[WIDTH-1:0];
        CARRY     <= single_res[WIDTH];
        OVF       <= 1'b0;
        OUT_VALID <= 1'b1;
      end else if ((state == ST_MUL) && mul_done) begin
        RESULT    <= mul_product[WIDTH-1:0];
        CARRY     <= 1'b0;
        OVF       <= |mul_product[2*WIDTH-1:WIDTH];
        OUT_VALID <= 1'b1;
      end else if (shift_done) begin
        RESULT    <= sh_next;
        CARRY     <= 1'b0;
        OVF       <= 1'b0;
        OUT_VALID <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8 and WIDTH=16 against an arithmetic reference model.
module tb_alu_seq;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        o;
    logic [7:0]  lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v8 = 1'b0, rdy8, ov8, z8, c8, o8;
  logic [7:0]  a8 = '0, b8 = '0, r8;
  logic [3:0]  s8 = '0;
  logic        v16 = 1'b0, rdy16, ov16, z16, c16, o16;
  logic [15:0] a16 = '0, b16 = '0, r16;
  logic [3:0]  s16 = '0;

  int tests_run = 0;
  int fails = 0;

  alu_seq #(.WIDTH(8)) dut8 (
    .CLK(clk), .RESET(rst), .IN_VALID(v8), .IN_READY(rdy8),
    .DATA1(a8), .DATA2(b8), .SELECT(s8), .OUT_VALID(ov8),
    .RESULT(r8), .ZERO(z8), .CARRY(c8), .OVF(o8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .CLK(clk), .RESET(rst), .IN_VALID(v16), .IN_READY(rdy16),
    .DATA1(a16), .DATA2(b16), .SELECT(s16), .OUT_VALID(ov16),
    .RESULT(r16), .ZERO(z16), .CARRY(c16), .OVF(o16)
  );

  // Reference: plain arithmetic on w-bit unsigned values; lat = edges after accept.
  function automatic exp_t model(input int w, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint unsigned mask, aa, bb, r;
    int s;
    mask = (64'd1 << w) - 1;
    aa = 64'(a) & mask;
    bb = 64'(b) & mask;
    s = int'(bb % 64'(w));
    r = 0;
    e = '0;
    case (op)
      4'd0: r = bb;
      4'd1: begin r = aa + bb; e.c = (r > mask); end
      4'd2: r = aa & bb;
      4'd3: r = aa | bb;
      4'd4: begin r = aa * bb; e.o = ((r >> w) != 0); e.lat = 8'(w); end
      4'd5: begin r = aa - bb; e.c = (aa >= bb); end
      4'd6: begin r = aa << s; e.lat = 8'(s); end
      4'd7: begin r = aa >> s; e.lat = 8'(s); end
      4'd8: begin
        r = aa >> s;
        if (aa[w-1]) r = r | (mask & ~(mask >> s));
        e.lat = 8'(s);
      end
      4'd9: begin r = (aa >> s) | (aa << (w - s)); e.lat = 8'(s); end
      default: r = 0;
    endcase
    e.res = 32'(r & mask);
    return e;
  endfunction

  task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output logic z, output logic c,
                        output logic o, output int lat, output int busy);
    @(negedge clk);
    s8 = op; a8 = a; b8 = b; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 4'($urandom);
    lat = 0; busy = 0;
    while (!ov8 && lat < 64) begin
      if (!rdy8) busy++;
      @(posedge clk); #1;
      lat++;
    end
    res = r8; z = z8; c = c8; o = o8;
  endtask

  task automatic issue16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] res, output logic z, output logic c,
                         output logic o, output int lat);
    @(negedge clk);
    s16 = op; a16 = a; b16 = b; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); s16 = 4'($urandom);
    lat = 0;
    while (!ov16 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    res = r16; z = z16; c = c16; o = o16;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({r8, z8, c8, o8, ov8, rdy8} !== {8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset8: got res=%h z=%b c=%b o=%b ov=%b rdy=%b, want 00 1 0 0 0 1",
               r8, z8, c8, o8, ov8, rdy8);
    end
    tests_run++;
    if ({r16, z16, c16, o16, ov16, rdy16} !== {16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset16: got res=%h z=%b ov=%b rdy=%b", r16, z16, ov16, rdy16);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({ov8, rdy8, r8} !== {1'b0, 1'b1, 8'h00}) begin
      fails++;
      $display("FAIL idle8: got ov=%b rdy=%b res=%h, want 0 1 00", ov8, rdy8, r8);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd10, 4'd11, 4'd13, 4'd15, 4'd6};
    exp_t e;
    @(negedge clk);
    s8 = 4'd1; a8 = 8'hF0; b8 = 8'h20; v8 = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({ov8, r8, c8, rdy8} !== {1'b1, 8'h10, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL b2b_add: got ov=%b res=%h c=%b rdy=%b, want 1 10 1 1", ov8, r8, c8, rdy8);
    end
    s8 = 4'd5; a8 = 8'h05; b8 = 8'h05;
    @(posedge clk); #1;
    tests_run++;
    if ({ov8, r8, z8, c8, rdy8} !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL b2b_sub: got ov=%b res=%h z=%b c=%b rdy=%b, want 1 00 1 1 1",
               ov8, r8, z8, c8, rdy8);
    end
    // continuous single-cycle stream, one op per clock
    for (int i = 0; i < 24; i++) begin
      s8 = ops[$urandom_range(0, 9)];
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      if (s8 == 4'd6) b8[2:0] = 3'd0;
      e = model(8, s8, 32'(a8), 32'(b8));
      @(posedge clk); #1;
      tests_run++;
      if ({ov8, rdy8, r8, z8, c8, o8} !== {1'b1, 1'b1, e.res[7:0], e.res[7:0] == 8'h0, e.c, e.o}) begin
        fails++;
        $display("FAIL stream op=%0d: got ov=%b rdy=%b res=%h c=%b o=%b, want 1 1 %h %b %b",
                 s8, ov8, rdy8, r8, c8, o8, e.res[7:0], e.c, e.o);
      end
    end
    v8 = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (ov8 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_pulse_end: got ov=%b, want 0", ov8);
    end
  endtask

  task automatic test_mul();
    logic [7:0] r; logic z, c, o; int lat, busy;
    issue8(4'd4, 8'h0C, 8'h0B, r, z, c, o, lat, busy);
    tests_run++;
    if ({r, z, c, o} !== {8'h84, 1'b0, 1'b0, 1'b0} || lat != 8 || busy != 8) begin
      fails++;
      $display("FAIL mul_0c_0b: got res=%h z=%b c=%b o=%b lat=%0d busy=%0d, want 84 0 0 0 8 8",
               r, z, c, o, lat, busy);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({ov8, r8, rdy8} !== {1'b0, 8'h84, 1'b1}) begin
      fails++;
      $display("FAIL mul_hold: got ov=%b res=%h rdy=%b, want 0 84 1", ov8, r8, rdy8);
    end
    issue8(4'd4, 8'h20, 8'h10, r, z, c, o, lat, busy);
    tests_run++;
    if ({r, z, o} !== {8'h00, 1'b1, 1'b1} || lat != 8) begin
      fails++;
      $display("FAIL mul_ovf: got res=%h z=%b o=%b lat=%0d, want 00 1 1 8", r, z, o, lat);
    end
    issue8(4'd4, 8'h37, 8'h00, r, z, c, o, lat, busy);
    tests_run++;
    if ({r, o} !== {8'h00, 1'b0} || lat != 8) begin
      fails++;
      $display("FAIL mul_zero: got res=%h o=%b lat=%0d, want 00 0 8", r, o, lat);
    end
  endtask

  task automatic test_shift();
    logic [3:0]  op  [5] = '{4'd8, 4'd7, 4'd9, 4'd6, 4'd7};
    logic [7:0]  amt [5] = '{8'h03, 8'h03, 8'h01, 8'h00, 8'h0B};
    logic [7:0]  want[5] = '{8'hF0, 8'h10, 8'hC0, 8'h81, 8'h10};
    int          wlat[5] = '{3, 3, 1, 0, 3};
    logic [7:0] r; logic z, c, o; int lat, busy;
    for (int i = 0; i < 5; i++) begin
      issue8(op[i], 8'h81, amt[i], r, z, c, o, lat, busy);
      tests_run++;
      if (r !== want[i] || {c, o} !== 2'b00 || lat != wlat[i]) begin
        fails++;
        $display("FAIL shift%0d op=%0d: got res=%h c=%b o=%b lat=%0d, want %h 0 0 %0d",
                 i, op[i], r, c, o, lat, want[i], wlat[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    logic [7:0] r; logic z, c, o; int lat, busy;
    issue8(4'd0, 8'h00, 8'hA5, r, z, c, o, lat, busy);
    @(negedge clk);
    s8 = 4'd4; a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({ov8, r8, z8, rdy8} !== {1'b0, 8'h00, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL rst_mid: got ov=%b res=%h z=%b rdy=%b, want 0 00 1 1", ov8, r8, z8, rdy8);
    end
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ov8) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL rst_mid_pulse: got %0d OUT_VALID pulses, want 0", pulses);
    end
    issue8(4'd0, 8'h12, 8'h55, r, z, c, o, lat, busy);
    tests_run++;
    if (r !== 8'h55 || lat != 0) begin
      fails++;
      $display("FAIL rst_mid_fwd: got res=%h lat=%0d, want 55 0", r, lat);
    end
  endtask

  task automatic test_undef();
    logic [7:0] r; logic z, c, o; int lat, busy;
    issue8(4'd1, 8'h01, 8'h02, r, z, c, o, lat, busy);
    issue8(4'b1111, 8'hFF, 8'hFF, r, z, c, o, lat, busy);
    tests_run++;
    if ({r, z, c, o} !== {8'h00, 1'b1, 1'b0, 1'b0} || lat != 0) begin
      fails++;
      $display("FAIL undef: got res=%h z=%b c=%b o=%b lat=%0d, want 00 1 0 0 0", r, z, c, o, lat);
    end
  endtask

  task automatic test_random8();
    logic [7:0] r, a, b; logic [3:0] op; logic z, c, o; int lat, busy;
    exp_t e;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      e = model(8, op, 32'(a), 32'(b));
      issue8(op, a, b, r, z, c, o, lat, busy);
      tests_run++;
      if ({r, z, c, o} !== {e.res[7:0], e.res[7:0] == 8'h0, e.c, e.o} || lat != int'(e.lat)) begin
        fails++;
        $display("FAIL rand8 op=%0d a=%h b=%h: got res=%h c=%b o=%b lat=%0d, want %h %b %b %0d",
                 op, a, b, r, c, o, lat, e.res[7:0], e.c, e.o, e.lat);
      end
    end
  endtask

  task automatic test_wide();
    logic [15:0] r, a, b; logic [3:0] op; logic z, c, o; int lat;
    exp_t e;
    issue16(4'd1, 16'hFFFF, 16'h0001, r, z, c, o, lat);
    tests_run++;
    if ({r, z, c} !== {16'h0000, 1'b1, 1'b1} || lat != 0) begin
      fails++;
      $display("FAIL add16: got res=%h z=%b c=%b lat=%0d, want 0000 1 1 0", r, z, c, lat);
    end
    issue16(4'd4, 16'h0100, 16'h0100, r, z, c, o, lat);
    tests_run++;
    if ({r, o} !== {16'h0000, 1'b1} || lat != 16) begin
      fails++;
      $display("FAIL mul16_ovf: got res=%h o=%b lat=%0d, want 0000 1 16", r, o, lat);
    end
    issue16(4'd4, 16'h00FF, 16'h0101, r, z, c, o, lat);
    tests_run++;
    if ({r, o} !== {16'hFFFF, 1'b0} || lat != 16) begin
      fails++;
      $display("FAIL mul16: got res=%h o=%b lat=%0d, want ffff 0 16", r, o, lat);
    end
    for (int i = 0; i < 16; i++) begin
      op = 4'($urandom_range(0, 9));
      a = 16'($urandom);
      b = 16'($urandom);
      e = model(16, op, 32'(a), 32'(b));
      issue16(op, a, b, r, z, c, o, lat);
      tests_run++;
      if ({r, z, c, o} !== {e.res[15:0], e.res[15:0] == 16'h0, e.c, e.o} || lat != int'(e.lat)) begin
        fails++;
        $display("FAIL rand16 op=%0d a=%h b=%h: got res=%h c=%b o=%b lat=%0d, want %h %b %b %0d",
                 op, a, b, r, c, o, lat, e.res[15:0], e.c, e.o, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mul();
    test_shift();
    test_reset_mid();
    test_undef();
    test_random8();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
